// File: rtl/vector_writeback_stage.sv
// vector_writeback_stage: lane-masked vector memory stage with one-cycle registered writeback
module vector_writeback_stage #(
  parameter int vecSize      = 4,
  parameter int registerSize = 16,
  parameter int memDepth     = 256,
  parameter int regAddrBits  = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  input  logic                                    stall,
  output logic                                    ready,
  input  logic                                    writeEnable,
  input  logic                                    writeMemFrom,
  input  logic [1:0]                              writeRegFrom,
  input  logic [vecSize-1:0]                      laneMask,
  input  logic [regAddrBits-1:0]                  rd_in,
  input  logic [registerSize-1:0]                 imm,
  input  logic [vecSize-1:0][registerSize-1:0]    aluResult,
  input  logic [vecSize-1:0][registerSize-1:0]    alu_operand1,
  input  logic [vecSize-1:0][registerSize-1:0]    alu_operand2,
  output logic [vecSize-1:0][registerSize-1:0]    writeBackData,
  output logic                                    wb_valid,
  output logic [regAddrBits-1:0]                  wb_rd,
  output logic                                    addr_error
);
  localparam int aw = (memDepth > 1) ? $clog2(memDepth) : 1;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_next;
  logic [aw-1:0] cnt;
  logic [vecSize-1:0][registerSize-1:0] mem [memDepth];
  logic [registerSize-1:0] addr;
  logic [aw-1:0] idx;
  logic in_range, accept, mem_op;
  logic [vecSize-1:0][registerSize-1:0] wdata, wb_next;
  logic unused_lanes;
  assign ready = state == RUN;
  assign accept = in_valid && ready && !stall;
  assign addr = writeMemFrom ? alu_operand2[0] : imm;
  assign in_range = {1'b0, addr} < (registerSize + 1)'(memDepth);
  assign idx = addr[aw-1:0];
  assign wdata = writeMemFrom ? alu_operand1 : aluResult;
  assign mem_op = writeEnable || writeRegFrom == 2'd0;
  assign unused_lanes = ^alu_operand2;
  // Read happens against pre-edge memory, so a same-op store+load sees old contents
  assign wb_next = writeRegFrom == 2'd0 ? (in_range ? mem[idx] : '0) :
                   writeRegFrom == 2'd1 ? wdata :
                   writeRegFrom == 2'd2 ? {vecSize{imm}} : '0;
  // Sweep ends on the last word; stall has no effect on the sweep
  always_comb begin
    state_next = (state == CLEAR && cnt == aw'(memDepth - 1)) ? RUN : state;
  end
  // State register and sweep index
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cnt <= cnt + aw'(1);
    end
  end
  // Memory: zero one word per cycle while clearing, masked lane stores while running
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (accept && writeEnable && in_range)
        for (int i = 0; i < vecSize; i++)
          if (laneMask[i]) mem[idx][i] <= wdata[i];
    end
  end
  // Writeback register; stall freezes everything, idle cycles only drop valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid      <= 1'b0;
      writeBackData <= '0;
      wb_rd         <= '0;
      addr_error    <= 1'b0;
    end else if (!stall) begin
      wb_valid <= accept;
      if (accept) begin
        writeBackData <= wb_next;
        wb_rd         <= rd_in;
        addr_error    <= addr_error | (mem_op & !in_range);
      end
    end
  end
endmodule

// File: tb/tb_vector_writeback_stage.sv
// tb_vector_writeback_stage: random and directed checks against a behavioural memory model
module tb_vector_writeback_stage;
  localparam int VS = 4, RS = 16, MD = 256, RB = 4;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, stall = 1'b0;
  logic writeEnable = 1'b0, writeMemFrom = 1'b0;
  logic [1:0] writeRegFrom = 2'd0;
  logic [VS-1:0] laneMask = '0;
  logic [RB-1:0] rd_in = '0;
  logic [RS-1:0] imm = '0;
  logic [VS-1:0][RS-1:0] aluResult = '0, alu_operand1 = '0, alu_operand2 = '0;
  logic [VS-1:0][RS-1:0] writeBackData;
  logic ready, wb_valid, addr_error;
  logic [RB-1:0] wb_rd;
  int checks = 0, failures = 0;

  vector_writeback_stage #(.vecSize(VS), .registerSize(RS), .memDepth(MD), .regAddrBits(RB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .ready(ready),
    .writeEnable(writeEnable), .writeMemFrom(writeMemFrom), .writeRegFrom(writeRegFrom),
    .laneMask(laneMask), .rd_in(rd_in), .imm(imm), .aluResult(aluResult),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .writeBackData(writeBackData),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .addr_error(addr_error));

  always #5 clk = ~clk;

  bit [15:0] m_mem [MD][VS];
  bit [15:0] m_data [VS];
  bit m_valid, m_err, m_run;
  bit [3:0] m_rd;
  int m_clr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_data();
    logic [63:0] r;
    for (int i = 0; i < VS; i++) r[i*16 +: 16] = m_data[i];
    return r;
  endfunction

  task automatic model_step();
    int a;
    bit inr;
    bit [15:0] old [VS];
    if (!reset) begin
      m_run = 0; m_clr = 0; m_valid = 0; m_err = 0; m_rd = 0;
      for (int i = 0; i < VS; i++) m_data[i] = 0;
    end else if (!m_run) begin
      m_clr++;
      if (m_clr == MD) begin
        m_run = 1;
        for (int w = 0; w < MD; w++) for (int i = 0; i < VS; i++) m_mem[w][i] = 0;
      end
    end else if (!stall) begin
      m_valid = in_valid;
      if (in_valid) begin
        a = writeMemFrom ? int'(alu_operand2[0]) : int'(imm);
        inr = a < MD;
        for (int i = 0; i < VS; i++) old[i] = inr ? m_mem[a][i] : 16'h0;
        for (int i = 0; i < VS; i++)
          case (writeRegFrom)
            2'd0: m_data[i] = old[i];
            2'd1: m_data[i] = writeMemFrom ? alu_operand1[i] : aluResult[i];
            2'd2: m_data[i] = imm;
            default: m_data[i] = 0;
          endcase
        if (writeEnable && inr)
          for (int i = 0; i < VS; i++)
            if (laneMask[i]) m_mem[a][i] = writeMemFrom ? alu_operand1[i] : aluResult[i];
        if (!inr && (writeEnable || writeRegFrom == 2'd0)) m_err = 1;
        m_rd = rd_in;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("ready", 64'(ready), 64'(m_run));
    check("wb_valid", 64'(wb_valid), 64'(m_valid));
    check("wb_rd", 64'(wb_rd), 64'(m_rd));
    check("addr_error", 64'(addr_error), 64'(m_err));
    check("wb_data", 64'(writeBackData), model_data());
  endtask

  task automatic set_op(input bit v, input bit we, input bit wmf, input bit [1:0] wrf,
                        input bit [3:0] mask, input bit [3:0] rd, input bit [15:0] im);
    in_valid = v; writeEnable = we; writeMemFrom = wmf; writeRegFrom = wrf;
    laneMask = mask; rd_in = rd; imm = im; stall = 1'b0;
  endtask

  function automatic bit [15:0] rand_addr();
    return ($urandom_range(0, 9) == 0) ? 16'($urandom_range(250, 300)) : 16'($urandom_range(0, 15));
  endfunction

  task automatic rand_inputs();
    set_op(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
           4'($urandom), 4'($urandom), rand_addr());
    if ($urandom_range(0, 7) == 0) imm = 16'($urandom);
    stall = ($urandom_range(0, 5) == 0);
    for (int i = 0; i < VS; i++) begin
      aluResult[i] = 16'($urandom);
      alu_operand1[i] = 16'($urandom);
      alu_operand2[i] = 16'($urandom);
    end
    alu_operand2[0] = rand_addr();
  endtask

  initial begin
    reset = 1'b0;
    cycle();
    cycle();
    check("reset_ready", 64'(ready), 64'h0);
    reset = 1'b1;
    for (int k = 0; k < MD; k++) begin
      in_valid = 1'b1;
      stall = ($urandom_range(0, 3) == 0);
      cycle();
    end
    check("clear_done_ready", 64'(ready), 64'h1);
    set_op(1, 0, 0, 0, 4'h0, 4'd1, 16'd5);
    cycle();
    check("load5_zero", 64'(writeBackData), 64'h0);
    aluResult = {16'd4, 16'd3, 16'd2, 16'd1};
    set_op(1, 1, 0, 1, 4'hF, 4'd2, 16'd10);
    cycle();
    set_op(1, 0, 0, 0, 4'h0, 4'd3, 16'd10);
    cycle();
    check("load10", 64'(writeBackData), 64'h0004_0003_0002_0001);
    check("load10_valid", 64'(wb_valid), 64'h1);
    alu_operand1 = {16'hA, 16'hB, 16'hC, 16'hD};
    alu_operand2 = {16'd0, 16'd0, 16'd0, 16'd10};
    set_op(1, 1, 1, 3, 4'b0101, 4'd4, 16'd0);
    cycle();
    set_op(1, 0, 0, 0, 4'h0, 4'd5, 16'd10);
    cycle();
    check("masked_load", 64'(writeBackData), 64'h0004_000B_0002_000D);
    set_op(1, 0, 0, 2, 4'h0, 4'd7, 16'h00FF);
    cycle();
    check("imm_rep", 64'(writeBackData), 64'h00FF_00FF_00FF_00FF);
    check("imm_rd", 64'(wb_rd), 64'd7);
    set_op(1, 0, 0, 3, 4'h0, 4'd8, 16'h00FF);
    cycle();
    check("zero_src", 64'(writeBackData), 64'h0);
    set_op(1, 0, 0, 0, 4'h0, 4'd9, 16'd10);
    cycle();
    aluResult = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    set_op(1, 1, 0, 1, 4'hF, 4'd1, 16'd10);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    check("stall_valid", 64'(wb_valid), 64'h1);
    check("stall_rd", 64'(wb_rd), 64'd9);
    set_op(0, 0, 0, 0, 4'h0, 4'd0, 16'd0);
    cycle();
    check("idle_valid", 64'(wb_valid), 64'h0);
    set_op(1, 0, 0, 0, 4'h0, 4'd2, 16'd10);
    cycle();
    check("no_write_in_stall", 64'(writeBackData), 64'h0004_000B_0002_000D);
    set_op(1, 1, 0, 1, 4'hF, 4'd3, 16'd300);
    cycle();
    check("oob_error", 64'(addr_error), 64'h1);
    set_op(0, 0, 0, 0, 4'h0, 4'd0, 16'd0);
    cycle();
    cycle();
    check("error_sticky", 64'(addr_error), 64'h1);
    set_op(1, 0, 0, 0, 4'h0, 4'd4, 16'd300);
    cycle();
    check("oob_read_zero", 64'(writeBackData), 64'h0);
    for (int k = 0; k < 1500; k++) begin
      rand_inputs();
      cycle();
    end
    reset = 1'b0;
    cycle();
    check("reset_err_clear", 64'(addr_error), 64'h0);
    reset = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rand_inputs();
      cycle();
    end
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    for (int k = 0; k < MD + 40; k++) begin
      rand_inputs();
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
